// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - MEM-stage data memory with fixed access latency and stall generation
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned accesses instead of truncating them.
module data_mem_stage #(
  parameter int AW  = 6,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  output logic [63:0] read_data,
  output logic        stall,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_C = 4'(LAT);

  state_t        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]    off_q, off_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          store_q, store_d;
  logic [63:0]   read_data_q, read_data_d;

  logic [63:0]   mem [0:(1<<AW)-1];

  logic          req;
  logic          trap;
  logic [2:0]    align_off;
  logic [63:0]   mem_rd;
  logic [63:0]   rd_shift;
  logic [63:0]   rd_ext;
  logic [63:0]   wr_shift;
  logic [7:0]    be;
  logic [63:0]   wmask;
  logic [63:0]   merged;
  logic          mem_we;
  logic          lat_hit;

  // Address bits above the array index are deliberately ignored (wrap-around).
  logic          unused_addr_bits;
  assign unused_addr_bits = ^addr[63:AW+3];

  // Request decode, natural alignment of the byte offset and optional trap detection.
  always_comb begin
    req       = memread | memwrite;
    align_off = addr[2:0];
    case (funct3[1:0])
      2'd1:    align_off = {addr[2:1], 1'b0};
      2'd2:    align_off = {addr[2], 2'b00};
      2'd3:    align_off = 3'b000;
      default: align_off = addr[2:0];
    endcase
`ifdef MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'd1:    trap = addr[0];
      2'd2:    trap = |addr[1:0];
      2'd3:    trap = |addr[2:0];
      default: trap = 1'b0;
    endcase
`else
    trap = 1'b0;
`endif
  end

  // Datapath for the latched access: aligned read, extension, and byte-merged write data.
  always_comb begin
    lat_hit  = (count_q == LAT_C);
    mem_rd   = mem[idx_q];
    rd_shift = mem_rd >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  rd_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  rd_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  rd_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
      3'b100:  rd_ext = {56'd0, rd_shift[7:0]};
      3'b101:  rd_ext = {48'd0, rd_shift[15:0]};
      3'b110:  rd_ext = {32'd0, rd_shift[31:0]};
      default: rd_ext = mem_rd;
    endcase
    case (funct3_q[1:0])
      2'd0:    be = 8'h01 << off_q;
      2'd1:    be = 8'h03 << off_q;
      2'd2:    be = 8'h0F << off_q;
      default: be = 8'hFF;
    endcase
    for (int i = 0; i < 8; i++) begin
      wmask[i*8 +: 8] = {8{be[i]}};
    end
    wr_shift = wdata_q << {off_q, 3'b000};
    merged   = (mem_rd & ~wmask) | (wr_shift & wmask);
    mem_we   = (state_q == BUSY) && lat_hit && store_q && !reset;
  end

  // Access FSM: next state, latched request fields, stall and misalign outputs.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    store_d     = store_q;
    read_data_d = read_data_q;
    stall       = 1'b0;
    misalign    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && trap) begin
          misalign    = 1'b1;
          read_data_d = 64'd0;
        end else if (req) begin
          stall    = 1'b1;
          idx_d    = addr[AW+2:3];
          off_d    = align_off;
          wdata_d  = wdata;
          funct3_d = funct3;
          store_d  = memwrite;
          count_d  = 4'd1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (!lat_hit) begin
          count_d = count_q + 4'd1;
        end else begin
          if (!store_q) begin
            read_data_d = rd_ext;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      idx_q       <= '0;
      off_q       <= 3'd0;
      wdata_q     <= 64'd0;
      funct3_q    <= 3'd0;
      store_q     <= 1'b0;
      read_data_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      store_q     <= store_d;
      read_data_q <= read_data_d;
    end
  end

  // Memory array write; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= merged;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - directed self-checking bench for data_mem_stage
module tb_data_mem_stage;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [63:0] read_data;
  logic        stall;
  logic        misalign;

  int passed = 0;
  int total  = 0;

  data_mem_stage #(.AW(6), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .memread   (memread),
    .memwrite  (memwrite),
    .funct3    (funct3),
    .read_data (read_data),
    .stall     (stall),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from IDLE and checks the stall profile and the DONE-cycle read_data.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] exp_rd);
    memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    check({tag, " stall_idle"}, 64'(stall), 64'd1);
    check({tag, " misalign"}, 64'(misalign), 64'd0);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      check({tag, " stall_busy"}, 64'(stall), 64'd1);
    end
    @(negedge clk);
    check({tag, " stall_done"}, 64'(stall), 64'd0);
    check({tag, " read_data"}, read_data, exp_rd);
    step();
    memread = 1'b0; memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; memread = 1'b0; memwrite = 1'b0; funct3 = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset read_data", read_data, 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset misalign", 64'(misalign), 64'd0);
    step();

    access("sd10", 1'b0, 1'b1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 64'd0);
    access("ld10", 1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 64'h0123456789ABCDEF);

    access("sb13", 1'b0, 1'b1, 3'b000, 64'h13, 64'h80, 64'h0123456789ABCDEF);
    access("lb13", 1'b1, 1'b0, 3'b000, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFF80);
    access("lbu13", 1'b1, 1'b0, 3'b100, 64'h13, 64'd0, 64'h0000000000000080);
    access("ld10b", 1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 64'h0123456780ABCDEF);
    access("lh12", 1'b1, 1'b0, 3'b001, 64'h12, 64'd0, 64'hFFFFFFFFFFFF80AB);
    access("lhu12", 1'b1, 1'b0, 3'b101, 64'h12, 64'd0, 64'h00000000000080AB);
    access("lwu14", 1'b1, 1'b0, 3'b110, 64'h14, 64'd0, 64'h0000000001234567);
    access("sh16", 1'b0, 1'b1, 3'b001, 64'h16, 64'hBEEF, 64'h0000000001234567);
    access("ld111_wrap", 1'b1, 1'b0, 3'b111, 64'h210, 64'd0, 64'hBEEF456780ABCDEF);
    access("rdwr_sb10", 1'b1, 1'b1, 3'b000, 64'h10, 64'h55, 64'hBEEF456780ABCDEF);
    access("lbu10", 1'b1, 1'b0, 3'b100, 64'h10, 64'd0, 64'h0000000000000055);

    access("sd20", 1'b0, 1'b1, 3'b011, 64'h20, 64'h11112222C3334444, 64'h0000000000000055);
    memwrite = 1'b1; funct3 = 3'b011; addr = 64'h20; wdata = 64'hAAAAAAAAAAAAAAAA;
    @(negedge clk);
    check("abandon stall_idle", 64'(stall), 64'd1);
    step();
    reset = 1'b1; memwrite = 1'b0;
    @(negedge clk);
    check("abandon stall_busy", 64'(stall), 64'd1);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abandon stall_after", 64'(stall), 64'd0);
    check("abandon read_data", read_data, 64'd0);
    step();
    access("ld20", 1'b1, 1'b0, 3'b011, 64'h20, 64'd0, 64'h11112222C3334444);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle stall", 64'(stall), 64'd0);
      check("idle read_data", read_data, 64'h11112222C3334444);
    end
    step();

`ifdef MISALIGN_TRAP_EN
    memread = 1'b1; funct3 = 3'b010; addr = 64'h22;
    @(negedge clk);
    check("lw22 misalign", 64'(misalign), 64'd1);
    check("lw22 stall", 64'(stall), 64'd0);
    step();
    memread = 1'b0;
    @(negedge clk);
    check("lw22 read_data", read_data, 64'd0);
    check("lw22 misalign_clear", 64'(misalign), 64'd0);
    check("lw22 stall_after", 64'(stall), 64'd0);
    step();
`else
    access("lw22", 1'b1, 1'b0, 3'b010, 64'h22, 64'd0, 64'hFFFFFFFFC3334444);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
